// File: rtl/div_result_bcd.sv
// Result stage for the 8-bit sequential divider: captures quotient/remainder and
// converts both to packed BCD with a shared double-dabble engine for the display.
module div_result_bcd #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  dbz_in,
   input  logic [WIDTH-1:0]      q_in,
   input  logic [WIDTH-1:0]      r_in,
   output logic                  busy,
   output logic                  done,
   output logic                  dbz_out,
   output logic [4*DIGITS-1:0]   bcd_q,
   output logic [4*DIGITS-1:0]   bcd_r
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, CONV_Q, CONV_R} state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] shift, hold;
   logic [BW-1:0]    scratch, q_park;
   logic [CW-1:0]    cnt;

   logic [BW-1:0]    scratch_adj, scratch_step;
   logic [WIDTH-1:0] shift_step;
   logic             last_step;
   logic             start, blank, park, finish;

   // One double-dabble step: per-nibble add-3 (no inter-nibble carry), then shift.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      scratch_adj = scratch;
      for (int i = 0; i < DIGITS; i++) begin
         if (scratch[4*i +: 4] >= 4'd5)
            scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
      // The bit shifted out of the top digit is always zero given the DIGITS bound.
      scratch_step = BW'({scratch_adj, shift[WIDTH-1]});
      shift_step   = {shift[WIDTH-2:0], 1'b0};
      last_step    = (cnt == LAST);
   end

   always_comb begin
      state_next = state;
      start      = 1'b0;
      blank      = 1'b0;
      park       = 1'b0;
      finish     = 1'b0;
      if (load && dbz_in) begin
         blank      = 1'b1;
         state_next = IDLE;
      end else if (load) begin
         start      = 1'b1;
         state_next = CONV_Q;
      end else begin
         case (state)
            CONV_Q: if (last_step) begin
               park       = 1'b1;
               state_next = CONV_R;
            end
            CONV_R: if (last_step) begin
               finish     = 1'b1;
               state_next = IDLE;
            end
            default: ;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift   <= '0;
         hold    <= '0;
         scratch <= '0;
         q_park  <= '0;
         cnt     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         dbz_out <= 1'b0;
         bcd_q   <= '0;
         bcd_r   <= '0;
      end else begin
         done <= 1'b0;
         if (start) begin
            shift   <= q_in;
            hold    <= r_in;
            scratch <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
         end else if (blank) begin
            // All-ones nibbles are the display's blank code.
            dbz_out <= 1'b1;
            bcd_q   <= '1;
            bcd_r   <= '1;
            done    <= 1'b1;
            busy    <= 1'b0;
         end else if (park) begin
            q_park  <= scratch_step;
            shift   <= hold;
            scratch <= '0;
            cnt     <= '0;
         end else if (finish) begin
            bcd_q   <= q_park;
            bcd_r   <= scratch_step;
            dbz_out <= 1'b0;
            done    <= 1'b1;
            busy    <= 1'b0;
            cnt     <= '0;
         end else if (state != IDLE) begin
            scratch <= scratch_step;
            shift   <= shift_step;
            cnt     <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_div_result_bcd.sv
// Directed bench for div_result_bcd: table of conversions plus hand-written
// sequences for divide-by-zero, restart, completion-edge load and mid-run reset.
module tb_div_result_bcd;

   logic        clk = 1'b0;
   logic        rst, load, dbz_in;
   logic [7:0]  q_in, r_in;
   logic        busy, done, dbz_out;
   logic [11:0] bcd_q, bcd_r;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [7:0]  q;
      logic [7:0]  r;
      logic [11:0] eq;
      logic [11:0] er;
   } vec_t;

   vec_t        vecs[5];
   logic [11:0] held_q, held_r;

   div_result_bcd #(.WIDTH(8), .DIGITS(3)) dut (
      .clk(clk), .rst(rst), .load(load), .dbz_in(dbz_in),
      .q_in(q_in), .r_in(r_in), .busy(busy), .done(done),
      .dbz_out(dbz_out), .bcd_q(bcd_q), .bcd_r(bcd_r)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Called at a negedge; load is sampled by the next posedge, returns at the following negedge.
   task automatic do_load(input logic [7:0] q, input logic [7:0] r, input logic dbz);
      q_in = q; r_in = r; dbz_in = dbz; load = 1'b1;
      @(negedge clk);
      load = 1'b0; dbz_in = 1'b0; q_in = 8'hAA; r_in = 8'h55;
   endtask

   task automatic run_conv(input string tag, input logic [11:0] eq, input logic [11:0] er,
                           input logic [11:0] hq, input logic [11:0] hr, input logic hdbz);
      int lat    = 0;
      int busy_n = 0;
      while (!done && lat < 40) begin
         if (busy) busy_n++;
         if (lat == 8) begin
            check({tag, " hold_q"}, bcd_q, hq);
            check({tag, " hold_r"}, bcd_r, hr);
            check({tag, " hold_dbz"}, dbz_out, hdbz);
         end
         @(negedge clk);
         lat++;
      end
      check({tag, " latency"}, lat, 16);
      check({tag, " busy_cycles"}, busy_n, 16);
      check({tag, " bcd_q"}, bcd_q, eq);
      check({tag, " bcd_r"}, bcd_r, er);
      check({tag, " dbz_out"}, dbz_out, 0);
      @(negedge clk);
      check({tag, " done_width"}, done, 0);
      check({tag, " busy_after"}, busy, 0);
   endtask

   initial begin
      int d;
      rst = 1'b1; load = 1'b0; dbz_in = 1'b0; q_in = '0; r_in = '0;
      repeat (2) @(negedge clk);
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      check("rst dbz_out", dbz_out, 0);
      check("rst bcd_q", bcd_q, 0);
      check("rst bcd_r", bcd_r, 0);
      rst = 1'b0;
      @(negedge clk);

      vecs[0] = '{q: 8'd255, r: 8'd0,  eq: 12'h255, er: 12'h000};
      vecs[1] = '{q: 8'd14,  r: 8'd2,  eq: 12'h014, er: 12'h002};
      vecs[2] = '{q: 8'd0,   r: 8'd99, eq: 12'h000, er: 12'h099};
      vecs[3] = '{q: 8'd128, r: 8'd7,  eq: 12'h128, er: 12'h007};
      vecs[4] = '{q: 8'd9,   r: 8'd10, eq: 12'h009, er: 12'h010};
      held_q = '0; held_r = '0;
      for (int i = 0; i < 5; i++) begin
         do_load(vecs[i].q, vecs[i].r, 1'b0);
         run_conv($sformatf("vec%0d", i), vecs[i].eq, vecs[i].er, held_q, held_r, 1'b0);
         held_q = vecs[i].eq; held_r = vecs[i].er;
      end

      // Divide by zero: immediate blank, no conversion.
      do_load(8'd3, 8'd1, 1'b1);
      check("dbz done", done, 1);
      check("dbz dbz_out", dbz_out, 1);
      check("dbz bcd_q", bcd_q, 12'hFFF);
      check("dbz bcd_r", bcd_r, 12'hFFF);
      check("dbz busy", busy, 0);
      @(negedge clk);
      check("dbz done_width", done, 0);
      check("dbz busy_after", busy, 0);
      do_load(8'd50, 8'd3, 1'b0);
      run_conv("dbz_clear", 12'h050, 12'h003, 12'hFFF, 12'hFFF, 1'b1);

      // Restart while busy: the 200/5 conversion must never complete.
      do_load(8'd200, 8'd5, 1'b0);
      d = 0;
      repeat (4) begin
         if (done) d++;
         @(negedge clk);
      end
      check("restart early_done", d, 0);
      do_load(8'd12, 8'd3, 1'b0);
      run_conv("restart", 12'h012, 12'h003, 12'h050, 12'h003, 1'b0);
      d = 0;
      repeat (20) begin
         @(negedge clk);
         if (done) d++;
      end
      check("restart extra_done", d, 0);

      // Load coincident with the final CONV_R step edge.
      do_load(8'd33, 8'd1, 1'b0);
      repeat (15) @(negedge clk);
      do_load(8'd61, 8'd8, 1'b0);
      check("final_edge done", done, 0);
      check("final_edge busy", busy, 1);
      check("final_edge bcd_q", bcd_q, 12'h012);
      run_conv("final_edge", 12'h061, 12'h008, 12'h012, 12'h003, 1'b0);

      // Asynchronous reset mid-conversion.
      do_load(8'd77, 8'd4, 1'b0);
      repeat (8) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst busy", busy, 0);
      check("midrst done", done, 0);
      check("midrst dbz_out", dbz_out, 0);
      check("midrst bcd_q", bcd_q, 0);
      check("midrst bcd_r", bcd_r, 0);
      @(negedge clk);
      rst = 1'b0;
      d = 0;
      repeat (25) begin
         @(negedge clk);
         if (done) d++;
      end
      check("midrst late_done", d, 0);
      do_load(8'd42, 8'd6, 1'b0);
      run_conv("after_rst", 12'h042, 12'h006, 12'h000, 12'h000, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
